// File: rtl/ahb_dma_write_checker.sv
// AHB DMA write-stream checker: compares memory writes against an expected
// data/address sequence. Optional capture ports: DMA_CHK_ERR_CAPTURE_EN.
module ahb_dma_write_checker #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 6,
    parameter int ADDR_STEP = 1,
    parameter int DATA_INC  = 1
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic [1:0]        HTRANS,
    input  logic              HREADY,
    input  logic [LEN_W-1:0]  cfg_words_n,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic              cfg_addr_dec,
    input  logic [DATA_W-1:0] init_data,
    input  logic              mem_write_flag,
    input  logic [ADDR_W-1:0] mem_WR_addr,
    input  logic [DATA_W-1:0] HWDATA_toMem,
    output logic              busy,
    output logic              data_error,
    output logic              addr_error,
    output logic              stray_error,
    output logic              len_error,
    output logic              done,
    output logic [LEN_W:0]    words_seen,
`ifdef DMA_CHK_ERR_CAPTURE_EN
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_exp_data,
    output logic [DATA_W-1:0] err_act_data,
`endif
    output logic [15:0]       err_count
);

    localparam logic [1:0]        TR_IDLE = 2'b00;
    localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(ADDR_STEP);
    localparam logic [DATA_W-1:0] INC_V   = DATA_W'(DATA_INC);
    localparam int                CNT_W   = LEN_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] exp_data_q, exp_data_d;
    logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
    logic [LEN_W-1:0]  cfg_words_q, cfg_words_d;
    logic              addr_dec_q, addr_dec_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic              data_err_q, data_err_d;
    logic              addr_err_q, addr_err_d;
    logic              stray_err_q, stray_err_d;
    logic              len_err_q, len_err_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [2:0]        n_err;
    logic [16:0]       cnt_sum;

    // Next state, expectation tracking and error pulse generation
    always_comb begin
        state_d     = state_q;
        exp_data_d  = exp_data_q;
        exp_addr_d  = exp_addr_q;
        cfg_words_d = cfg_words_q;
        addr_dec_d  = addr_dec_q;
        words_d     = words_q;
        data_err_d  = 1'b0;
        addr_err_d  = 1'b0;
        stray_err_d = 1'b0;
        len_err_d   = 1'b0;
        done_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                stray_err_d = mem_write_flag;
                if (HTRANS != TR_IDLE) begin
                    state_d     = S_CHECK;
                    exp_data_d  = init_data;
                    exp_addr_d  = cfg_base_addr;
                    cfg_words_d = cfg_words_n;
                    addr_dec_d  = cfg_addr_dec;
                    words_d     = '0;
                end
            end
            S_CHECK: begin
                if (mem_write_flag) begin
                    data_err_d = (HWDATA_toMem != exp_data_q);
                    addr_err_d = (mem_WR_addr != exp_addr_q);
                    exp_data_d = exp_data_q + INC_V;
                    exp_addr_d = addr_dec_q ? exp_addr_q - STEP_V
                                            : exp_addr_q + STEP_V;
                    if (words_q != '1) begin
                        words_d = words_q + CNT_W'(1);
                    end
                end
                if (HREADY && (HTRANS == TR_IDLE)) begin
                    state_d   = S_REPORT;
                    done_d    = 1'b1;
                    len_err_d = (words_d != {1'b0, cfg_words_q});
                end
            end
            S_REPORT: begin
                stray_err_d = mem_write_flag;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_CHECK);
    end

    // Saturating total of the error pulses currently on the outputs
    always_comb begin
        n_err = 3'(data_err_q) + 3'(addr_err_q)
              + 3'(stray_err_q) + 3'(len_err_q);
        cnt_sum   = {1'b0, err_cnt_q} + 17'(n_err);
        err_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    // State and output registers
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            exp_data_q  <= '0;
            exp_addr_q  <= '0;
            cfg_words_q <= '0;
            addr_dec_q  <= 1'b0;
            words_q     <= '0;
            data_err_q  <= 1'b0;
            addr_err_q  <= 1'b0;
            stray_err_q <= 1'b0;
            len_err_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            exp_data_q  <= exp_data_d;
            exp_addr_q  <= exp_addr_d;
            cfg_words_q <= cfg_words_d;
            addr_dec_q  <= addr_dec_d;
            words_q     <= words_d;
            data_err_q  <= data_err_d;
            addr_err_q  <= addr_err_d;
            stray_err_q <= stray_err_d;
            len_err_q   <= len_err_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign busy        = busy_q;
    assign data_error  = data_err_q;
    assign addr_error  = addr_err_q;
    assign stray_error = stray_err_q;
    assign len_error   = len_err_q;
    assign done        = done_q;
    assign words_seen  = words_q;
    assign err_count   = err_cnt_q;

`ifdef DMA_CHK_ERR_CAPTURE_EN
    logic              err_valid_q, err_valid_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [DATA_W-1:0] err_exp_q, err_exp_d;
    logic [DATA_W-1:0] err_act_q, err_act_d;

    // Hold the first data/address mismatch seen since reset
    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        err_exp_d   = err_exp_q;
        err_act_d   = err_act_q;
        if (!err_valid_q && (data_err_d || addr_err_d)) begin
            err_valid_d = 1'b1;
            err_addr_d  = mem_WR_addr;
            err_exp_d   = exp_data_q;
            err_act_d   = HWDATA_toMem;
        end
    end

    // Capture registers, sticky until reset
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_exp_q   <= '0;
            err_act_q   <= '0;
        end else begin
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_exp_q   <= err_exp_d;
            err_act_q   <= err_act_d;
        end
    end

    assign err_valid    = err_valid_q;
    assign err_addr     = err_addr_q;
    assign err_exp_data = err_exp_q;
    assign err_act_data = err_act_q;
`endif

endmodule

// File: tb/tb_ahb_dma_write_checker.sv
// Bench for ahb_dma_write_checker: two instances (ADDR_STEP 1 and 4) driven
// by the same directed stimulus, checked against a sequence-level model.
module tb_ahb_dma_write_checker;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic [5:0]  cfg_words_n;
    logic [31:0] cfg_base_addr;
    logic        cfg_addr_dec;
    logic [31:0] init_data;
    logic        mem_write_flag;
    logic [31:0] mem_WR_addr;
    logic [31:0] HWDATA_toMem;

    logic        busy_o [2];
    logic        de_o   [2];
    logic        ae_o   [2];
    logic        se_o   [2];
    logic        le_o   [2];
    logic        done_o [2];
    logic [6:0]  ws_o   [2];
    logic [15:0] cnt_o  [2];
`ifdef DMA_CHK_ERR_CAPTURE_EN
    logic        cv_o [2];
    logic [31:0] ca_o [2];
    logic [31:0] cx_o [2];
    logic [31:0] cy_o [2];
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;
    int done_seen [2] = '{0, 0};

    always #5 HCLK = ~HCLK;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ahb_dma_write_checker #(
            .DATA_W(32), .ADDR_W(32), .LEN_W(6),
            .ADDR_STEP(g == 0 ? 1 : 4), .DATA_INC(1)
        ) dut (
            .HCLK(HCLK),
            .HRESET(HRESET),
            .HTRANS(HTRANS),
            .HREADY(HREADY),
            .cfg_words_n(cfg_words_n),
            .cfg_base_addr(cfg_base_addr),
            .cfg_addr_dec(cfg_addr_dec),
            .init_data(init_data),
            .mem_write_flag(mem_write_flag),
            .mem_WR_addr(mem_WR_addr),
            .HWDATA_toMem(HWDATA_toMem),
            .busy(busy_o[g]),
            .data_error(de_o[g]),
            .addr_error(ae_o[g]),
            .stray_error(se_o[g]),
            .len_error(le_o[g]),
            .done(done_o[g]),
            .words_seen(ws_o[g]),
`ifdef DMA_CHK_ERR_CAPTURE_EN
            .err_valid(cv_o[g]),
            .err_addr(ca_o[g]),
            .err_exp_data(cx_o[g]),
            .err_act_data(cy_o[g]),
`endif
            .err_count(cnt_o[g])
        );
    end

    // Model: expected word k is init + k, address base -/+ k*step
    int          m_mode [2];
    int          m_k    [2];
    int          m_cnt  [2];
    int          m_words[2];
    logic [31:0] m_base [2];
    logic [31:0] m_init [2];
    logic        m_dec  [2];
    logic [5:0]  m_len  [2];
    logic        m_de [2], m_ae [2], m_se [2], m_le [2];
    logic        m_done [2], m_busy [2];
    logic        m_cv [2];
    logic [31:0] m_ca [2], m_cx [2], m_cy [2];
    int          m_add, m_stp;
    logic [31:0] m_ea, m_ed;

    always @(posedge HCLK) begin
        for (int u = 0; u < 2; u++) begin
            m_stp = (u == 0) ? 1 : 4;
            if (HRESET) begin
                m_mode[u] = 0; m_k[u] = 0; m_cnt[u] = 0; m_words[u] = 0;
                m_base[u] = '0; m_init[u] = '0; m_dec[u] = 0; m_len[u] = '0;
                m_de[u] = 0; m_ae[u] = 0; m_se[u] = 0; m_le[u] = 0;
                m_done[u] = 0; m_busy[u] = 0;
                m_cv[u] = 0; m_ca[u] = '0; m_cx[u] = '0; m_cy[u] = '0;
            end else begin
                m_add = int'(m_de[u]) + int'(m_ae[u])
                      + int'(m_se[u]) + int'(m_le[u]);
                m_cnt[u] = (m_cnt[u] + m_add > 65535) ? 65535
                                                      : m_cnt[u] + m_add;
                m_de[u] = 0; m_ae[u] = 0; m_se[u] = 0; m_le[u] = 0;
                m_done[u] = 0;
                if (m_mode[u] == 0) begin
                    m_se[u] = mem_write_flag;
                    if (HTRANS != 2'b00) begin
                        m_mode[u] = 1; m_k[u] = 0;
                        m_base[u] = cfg_base_addr; m_init[u] = init_data;
                        m_dec[u] = cfg_addr_dec; m_len[u] = cfg_words_n;
                    end
                end else if (m_mode[u] == 1) begin
                    if (mem_write_flag) begin
                        m_ed = m_init[u] + 32'(m_k[u]);
                        m_ea = m_dec[u] ? m_base[u] - 32'(m_k[u] * m_stp)
                                        : m_base[u] + 32'(m_k[u] * m_stp);
                        m_de[u] = (HWDATA_toMem != m_ed);
                        m_ae[u] = (mem_WR_addr != m_ea);
                        if (!m_cv[u] && (m_de[u] || m_ae[u])) begin
                            m_cv[u] = 1; m_ca[u] = mem_WR_addr;
                            m_cx[u] = m_ed; m_cy[u] = HWDATA_toMem;
                        end
                        m_k[u] = m_k[u] + 1;
                    end
                    if (HREADY && HTRANS == 2'b00) begin
                        m_done[u] = 1;
                        m_le[u] = (((m_k[u] > 127) ? 127 : m_k[u])
                                   != int'(m_len[u]));
                        m_mode[u] = 2;
                    end
                end else begin
                    m_se[u] = mem_write_flag;
                    m_mode[u] = 0;
                end
                m_busy[u] = (m_mode[u] == 1);
                m_words[u] = (m_k[u] > 127) ? 127 : m_k[u];
            end
        end
    end

    task automatic chk(input int u, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL u%0d %s: got %0h expected %0h", u, nm, act, exp);
        end
    endtask

    // Every cycle: DUT outputs against the model
    always @(negedge HCLK) begin
        if (cmp_en) begin
            for (int u = 0; u < 2; u++) begin
                chk(u, "busy", 32'(busy_o[u]), 32'(m_busy[u]));
                chk(u, "data_error", 32'(de_o[u]), 32'(m_de[u]));
                chk(u, "addr_error", 32'(ae_o[u]), 32'(m_ae[u]));
                chk(u, "stray_error", 32'(se_o[u]), 32'(m_se[u]));
                chk(u, "len_error", 32'(le_o[u]), 32'(m_le[u]));
                chk(u, "done", 32'(done_o[u]), 32'(m_done[u]));
                chk(u, "words_seen", 32'(ws_o[u]), 32'(m_words[u]));
                chk(u, "err_count", 32'(cnt_o[u]), 32'(m_cnt[u]));
`ifdef DMA_CHK_ERR_CAPTURE_EN
                chk(u, "err_valid", 32'(cv_o[u]), 32'(m_cv[u]));
                chk(u, "err_addr", ca_o[u], m_ca[u]);
                chk(u, "err_exp_data", cx_o[u], m_cx[u]);
                chk(u, "err_act_data", cy_o[u], m_cy[u]);
`endif
                if (done_o[u] === 1'b1) done_seen[u]++;
            end
        end
    end

    task automatic step(input logic [1:0] tr, input logic rdy,
                        input logic wr, input logic [31:0] a,
                        input logic [31:0] d);
        @(negedge HCLK);
        HTRANS = tr; HREADY = rdy; mem_write_flag = wr;
        mem_WR_addr = a; HWDATA_toMem = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 1'b1, 1'b0, '0, '0);
    endtask

    task automatic run_xfer(input logic [31:0] base, input logic dec,
                            input int astep, input logic [31:0] init,
                            input int nb, input logic [5:0] wn,
                            input int bad, input logic coinc,
                            input logic stall, input logic exp_len);
        logic [31:0] a, d;
        int d0;
        d0 = done_seen[0];
        cfg_base_addr = base; cfg_addr_dec = dec;
        init_data = init; cfg_words_n = wn;
        step(2'b10, 1'b1, 1'b0, '0, '0);
        for (int i = 0; i < nb; i++) begin
            a = dec ? base - 32'(i * astep) : base + 32'(i * astep);
            d = (i == bad) ? 32'h99 : init + 32'(i);
            step((coinc && i == nb - 1) ? 2'b00 : 2'b11, 1'b1, 1'b1, a, d);
            if (i == 0) begin
                cfg_base_addr = ~base; cfg_addr_dec = ~dec;
                init_data = ~init; cfg_words_n = ~wn;
            end
            if (bad >= 0 && i > 0)
                chk(0, "lit data_error", 32'(de_o[0]), 32'(i - 1 == bad));
            if (stall && i == 0) begin
                step(2'b01, 1'b1, 1'b0, '0, '0);
                step(2'b11, 1'b0, 1'b0, '0, '0);
                step(2'b00, 1'b0, 1'b0, '0, '0);
            end
        end
        if (!coinc) idle(1);
        idle(1);
        chk(0, "lit done", 32'(done_o[0]), 32'd1);
        chk(0, "lit len_error", 32'(le_o[0]), 32'(exp_len));
        chk(0, "lit busy report", 32'(busy_o[0]), 32'd0);
        idle(2);
        chk(0, "lit done once", 32'(done_seen[0] - d0), 32'd1);
    endtask

    initial begin
        int d0;
        HRESET = 1'b1; HTRANS = 2'b00; HREADY = 1'b1;
        cfg_words_n = '0; cfg_base_addr = '0; cfg_addr_dec = 1'b0;
        init_data = '0; mem_write_flag = 1'b0;
        mem_WR_addr = '0; HWDATA_toMem = '0;
        repeat (2) @(negedge HCLK);
        cmp_en = 1'b1;
        chk(0, "lit reset busy", 32'(busy_o[0]), 32'd0);
        chk(0, "lit reset words", 32'(ws_o[0]), 32'd0);
        chk(0, "lit reset count", 32'(cnt_o[0]), 32'd0);
        chk(1, "lit reset done", 32'(done_o[1]), 32'd0);
        HRESET = 1'b0;
        idle(2);

        run_xfer(32'h100, 1'b1, 1, 32'h10, 4, 6'd4, -1, 1'b1, 1'b0, 1'b0);
        chk(0, "lit t1 words", 32'(ws_o[0]), 32'd4);
        chk(0, "lit t1 count", 32'(cnt_o[0]), 32'd0);
        chk(1, "lit t1 count", 32'(cnt_o[1]), 32'd3);

        run_xfer(32'h100, 1'b1, 1, 32'h10, 4, 6'd4, 2, 1'b1, 1'b0, 1'b0);
        chk(0, "lit t2 count", 32'(cnt_o[0]), 32'd1);
        chk(1, "lit t2 count", 32'(cnt_o[1]), 32'd7);
`ifdef DMA_CHK_ERR_CAPTURE_EN
        chk(0, "lit cap valid", 32'(cv_o[0]), 32'd1);
        chk(0, "lit cap addr", ca_o[0], 32'hFE);
        chk(0, "lit cap exp", cx_o[0], 32'h12);
        chk(0, "lit cap act", cy_o[0], 32'h99);
`endif

        run_xfer(32'hFFFF_FFF8, 1'b0, 4, 32'h20, 3, 6'd3, -1,
                 1'b0, 1'b1, 1'b0);
        chk(1, "lit t3 count", 32'(cnt_o[1]), 32'd7);
        chk(1, "lit t3 words", 32'(ws_o[1]), 32'd3);
        chk(0, "lit t3 count", 32'(cnt_o[0]), 32'd3);

        run_xfer(32'h100, 1'b1, 1, 32'h10, 3, 6'd4, -1, 1'b1, 1'b0, 1'b1);
        chk(0, "lit t4 words", 32'(ws_o[0]), 32'd3);
        chk(0, "lit t4 count", 32'(cnt_o[0]), 32'd4);
        chk(1, "lit t4 count", 32'(cnt_o[1]), 32'd10);

        run_xfer(32'h100, 1'b1, 1, 32'h10, 4, 6'd4, -1, 1'b1, 1'b0, 1'b0);
        chk(0, "lit t5 count", 32'(cnt_o[0]), 32'd4);
        chk(1, "lit t5 count", 32'(cnt_o[1]), 32'd13);

        HRESET = 1'b1;
        idle(1);
        HRESET = 1'b0;
        idle(1);
        chk(0, "lit rst count", 32'(cnt_o[0]), 32'd0);
        step(2'b00, 1'b1, 1'b1, 32'h55, 32'h55);
        idle(1);
        chk(0, "lit stray", 32'(se_o[0]), 32'd1);
        idle(1);
        chk(0, "lit stray clr", 32'(se_o[0]), 32'd0);
        chk(0, "lit stray count", 32'(cnt_o[0]), 32'd1);

        d0 = done_seen[0];
        cfg_base_addr = 32'h100; cfg_addr_dec = 1'b1;
        init_data = 32'h10; cfg_words_n = 6'd4;
        step(2'b10, 1'b1, 1'b0, '0, '0);
        step(2'b11, 1'b1, 1'b1, 32'h100, 32'h10);
        step(2'b11, 1'b1, 1'b1, 32'hFF, 32'h11);
        chk(0, "lit mid busy", 32'(busy_o[0]), 32'd1);
        step(2'b11, 1'b1, 1'b1, 32'hFE, 32'h12);
        HRESET = 1'b1;
        step(2'b00, 1'b1, 1'b0, '0, '0);
        HRESET = 1'b0;
        for (int u = 0; u < 2; u++) begin
            chk(u, "lit rst2 busy", 32'(busy_o[u]), 32'd0);
            chk(u, "lit rst2 words", 32'(ws_o[u]), 32'd0);
            chk(u, "lit rst2 count", 32'(cnt_o[u]), 32'd0);
            chk(u, "lit rst2 done", 32'(done_o[u]), 32'd0);
            chk(u, "lit rst2 len", 32'(le_o[u]), 32'd0);
        end
        idle(3);
        chk(0, "lit rst2 no done", 32'(done_seen[0] - d0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
